// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//
// Purpose:
//   Registered ripple-carry binary adder computing in_1 + in_2 + carry_in.
//   WIDTH=1 is the classic 1-bit full adder; wider instances act as datapath
//   adders. All outputs come straight from flops (one-cycle latency), so
//   instances can be chained through carry_out -> carry_in without building a
//   combinational carry path across stages.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous, active-high reset (wins over in_valid)
//   in_1       in   WIDTH  operand A (unsigned; MSB also read as sign)
//   in_2       in   WIDTH  operand B
//   carry_in   in   1      carry into bit 0
//   in_valid   in   1      capture operands on this edge
//   sum        out  WIDTH  registered low WIDTH bits of the total
//   carry_out  out  1      registered carry out of bit WIDTH-1
//   overflow   out  1      registered two's-complement overflow
//   out_valid  out  1      sum/carry_out/overflow hold a fresh result
//
// Valid semantics: there is no ready/backpressure. A result is produced for
// every edge where in_valid=1 and rst=0, and out_valid is high for exactly the
// following cycle. On edges with in_valid=0 the data outputs keep their last
// value and only out_valid drops.
// -----------------------------------------------------------------------------
module full_adder #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_1,
    input  logic [WIDTH-1:0] in_2,
    input  logic             carry_in,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             out_valid
);

    // Next-state values for the result registers.
    logic [WIDTH-1:0] sum_d;
    logic             carry_d;
    logic             ovf_d;
    logic             valid_d;

    // Result registers.
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             ovf_q;
    logic             valid_q;

    // Ripple-carry adder: one full-adder cell per bit, carry walking upward.
    always_comb begin : ripple
        logic [WIDTH:0] chain;
        chain    = '0;
        sum_d    = '0;
        chain[0] = carry_in;
        for (int i = 0; i < WIDTH; i++) begin
            sum_d[i]     = in_1[i] ^ in_2[i] ^ chain[i];
            chain[i + 1] = (in_1[i] & in_2[i]) | (chain[i] & (in_1[i] ^ in_2[i]));
        end
        carry_d = chain[WIDTH];
        // Signed overflow: both operands share a sign the result does not.
        ovf_d   = (in_1[WIDTH-1] == in_2[WIDTH-1]) && (sum_d[WIDTH-1] != in_1[WIDTH-1]);
        valid_d = in_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            // Data registers only load on a valid beat so idle cycles hold
            // the last result for anyone still sampling it.
            if (in_valid) begin
                sum_q   <= sum_d;
                carry_q <= carry_d;
                ovf_q   <= ovf_d;
            end
        end
    end

    assign sum       = sum_q;
    assign carry_out = carry_q;
    assign overflow  = ovf_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_full_adder.sv
// -----------------------------------------------------------------------------
// tb_full_adder
//   Drives a 1-bit and an 8-bit full_adder side by side. Expected results come
//   from an integer-arithmetic model of the adder's rules and are queued in
//   exp_q at each edge, then popped and compared one time unit later. Inputs
//   are scrambled between edges to show outputs only move on clk.
// -----------------------------------------------------------------------------
module tb_full_adder;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // ---------------- DUT signals ----------------
    logic [0:0] a1, b1, s1;
    logic       c1, v1, co1, ov1, ov_valid1;
    logic [7:0] a8, b8, s8;
    logic       c8, v8, co8, ov8, ov_valid8;

    full_adder #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst),
        .in_1(a1), .in_2(b1), .carry_in(c1), .in_valid(v1),
        .sum(s1), .carry_out(co1), .overflow(ov1), .out_valid(ov_valid1)
    );

    full_adder #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst),
        .in_1(a8), .in_2(b8), .carry_in(c8), .in_valid(v8),
        .sum(s8), .carry_out(co8), .overflow(ov8), .out_valid(ov_valid8)
    );

    // ---------------- scoreboard ----------------
    int tests_run    = 0;
    int tests_failed = 0;

    // Packed expectation: {valid, overflow, carry, sum[7:0]}
    logic [10:0] exp_q[$];

    // Model state per instance (index 0: WIDTH=1, index 1: WIDTH=8).
    int m_sum[2];
    int m_co[2];
    int m_ovf[2];
    int m_val[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic, signed overflow by range check.
    task automatic model_step(input int idx, input int w, input bit r, input bit v,
                              input int a, input int b, input int c);
        int full, lim, sa, sb, st;
        logic [10:0] e;
        if (r) begin
            m_sum[idx] = 0; m_co[idx] = 0; m_ovf[idx] = 0; m_val[idx] = 0;
        end else if (v) begin
            full       = a + b + c;
            m_sum[idx] = full % (1 << w);
            m_co[idx]  = full >> w;
            lim        = 1 << (w - 1);
            sa         = (a >= lim) ? a - 2 * lim : a;
            sb         = (b >= lim) ? b - 2 * lim : b;
            st         = sa + sb + c;
            m_ovf[idx] = (st >= lim || st < -lim) ? 1 : 0;
            m_val[idx] = 1;
        end else begin
            m_val[idx] = 0;
        end
        e = {1'(m_val[idx]), 1'(m_ovf[idx]), 1'(m_co[idx]), 8'(m_sum[idx])};
        exp_q.push_back(e);
    endtask

    // ---------------- driver ----------------
    task automatic step(input string tag, input bit r,
                        input bit va, input int aa, input int ba, input int ca,
                        input bit vb, input int ab, input int bb, input int cb);
        logic [10:0] e;
        @(negedge clk);
        rst = r;
        v1 = va; a1 = 1'(aa); b1 = 1'(ba); c1 = 1'(ca);
        v8 = vb; a8 = 8'(ab); b8 = 8'(bb); c8 = 1'(cb);
        @(posedge clk);
        model_step(0, 1, r, va, aa, ba, ca);
        model_step(1, 8, r, vb, ab, bb, cb);
        #1;
        e = exp_q.pop_front();
        check({tag, "/w1_sum"}, 32'(s1),        32'(e[7:0]));
        check({tag, "/w1_co"},  32'(co1),       32'(e[8]));
        check({tag, "/w1_ovf"}, 32'(ov1),       32'(e[9]));
        check({tag, "/w1_vld"}, 32'(ov_valid1), 32'(e[10]));
        e = exp_q.pop_front();
        check({tag, "/w8_sum"}, 32'(s8),        32'(e[7:0]));
        check({tag, "/w8_co"},  32'(co8),       32'(e[8]));
        check({tag, "/w8_ovf"}, 32'(ov8),       32'(e[9]));
        check({tag, "/w8_vld"}, 32'(ov_valid8), 32'(e[10]));
        // Scramble inputs mid-cycle; registered outputs must not move.
        #2;
        a8 = 8'($urandom_range(0, 255)); b8 = 8'($urandom_range(0, 255));
        c8 = 1'($urandom_range(0, 1));   v8 = ~v8;
        a1 = ~a1; c1 = ~c1; rst = ~rst;
        #1;
        check({tag, "/w8_sum_hold"}, 32'(s8),        32'(m_sum[1]));
        check({tag, "/w8_vld_hold"}, 32'(ov_valid8), 32'(m_val[1]));
        check({tag, "/w1_sum_hold"}, 32'(s1),        32'(m_sum[0]));
    endtask

    // ---------------- stimulus ----------------
    int t_a[6] = '{0, 0, 1, 1, 0, 1};
    int t_b[6] = '{0, 1, 0, 1, 0, 1};
    int t_c[6] = '{0, 0, 0, 0, 1, 1};
    // 8-bit directed cases: a, b, cin, expected sum, co, ovf
    int d_a[3]   = '{8'hFF, 8'h7F, 8'h80};
    int d_b[3]   = '{8'h01, 8'h01, 8'h80};
    int d_c[3]   = '{0, 0, 1};
    int d_s[3]   = '{8'h00, 8'h80, 8'h01};
    int d_co[3]  = '{1, 0, 1};
    int d_ovf[3] = '{0, 1, 1};
    // 1-bit directed expectations (sum, co)
    int e1_s[6]  = '{0, 1, 1, 0, 1, 1};
    int e1_co[6] = '{0, 0, 0, 1, 0, 1};

    initial begin
        rst = 1'b1;
        v1 = 1'b0; a1 = '0; b1 = '0; c1 = 1'b0;
        v8 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0;

        // Reset for two edges.
        step("reset0", 1'b1, 1'b1, 1, 1, 1, 1'b1, 255, 255, 1);
        step("reset1", 1'b1, 1'b1, 1, 1, 1, 1'b1, 255, 255, 1);
        check("reset_sum_zero", 32'(s8), 32'd0);

        // 1-bit truth-table walk.
        for (int i = 0; i < 6; i++) begin
            step("w1_table", 1'b0, 1'b1, t_a[i], t_b[i], t_c[i],
                 1'b1, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1));
            check("w1_table_sum_const", 32'(s1),  32'(e1_s[i]));
            check("w1_table_co_const",  32'(co1), 32'(e1_co[i]));
        end

        // 8-bit boundary cases.
        for (int i = 0; i < 3; i++) begin
            step("w8_dir", 1'b0, 1'b1, 1, 0, 0, 1'b1, d_a[i], d_b[i], d_c[i]);
            check("w8_dir_sum_const", 32'(s8),  32'(d_s[i]));
            check("w8_dir_co_const",  32'(co8), 32'(d_co[i]));
            check("w8_dir_ovf_const", 32'(ov8), 32'(d_ovf[i]));
        end

        // Idle for three cycles: valid drops, data holds 0x01/co=1/ovf=1.
        for (int i = 0; i < 3; i++) begin
            step("idle", 1'b0, 1'b0, 0, 0, 0, 1'b0, 0, 0, 0);
            check("idle_sum_held", 32'(s8),        32'h01);
            check("idle_vld_low",  32'(ov_valid8), 32'd0);
        end

        // Reset in the middle of a valid stream, then resume.
        step("stream", 1'b0, 1'b1, 1, 1, 0, 1'b1, 8'h12, 8'h34, 0);
        step("mid_rst", 1'b1, 1'b1, 1, 1, 1, 1'b1, 8'hAA, 8'h55, 1);
        check("mid_rst_vld", 32'(ov_valid8), 32'd0);
        step("resume", 1'b0, 1'b1, 0, 1, 1, 1'b1, 8'h40, 8'h40, 0);
        check("resume_sum_const", 32'(s8),  32'h80);
        check("resume_ovf_const", 32'(ov8), 32'd1);

        // Random traffic with occasional idle cycles and resets.
        for (int i = 0; i < 1000; i++) begin
            step("rand", ($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 7) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 1),
                 ($urandom_range(0, 9) != 0), $urandom_range(0, 255), $urandom_range(0, 255),
                 $urandom_range(0, 1));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
